satd_hadamard_acc: RTL and testbench

Downstream stage of the SATD datapath: consumes the 16 signed pixel differences of a 4x4 block, one per clock in raster order, from the difference stage that the SATD control FSM enables and counts. It applies a 2-D 4-point Hadamard transform (rows as they complete, then columns) and sums the absolute coefficients. It emits the unnormalized SATD with a one-cycle valid pulse.

---
 rtl/satd_hadamard_acc.sv | 159 +++++++++++++++
 tb/tb_satd_hadamard_acc.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/satd_hadamard_acc.sv
// satd_hadamard_acc: 4x4 Hadamard transform and |coeff| accumulator.
// Rows are transformed as they arrive; columns are summed over four cycles.
module satd_hadamard_acc #(
    parameter int DW = 9,
    parameter int SW = DW + 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 diff_valid,
    input  logic signed [DW-1:0] diff_in,
    output logic                 busy,
    output logic                 satd_valid,
    output logic [SW-1:0]        satd_out,
    output logic                 overrun
);

    localparam int RW = DW + 2;
    localparam int CW = DW + 4;

    typedef enum logic {LOAD, COL} state_t;

    state_t state_q, state_d;
    logic [3:0]    idx_q, idx_d;
    logic [1:0]    c_q, c_d;
    logic [SW-1:0] acc_q, acc_d;
    logic [SW-1:0] satd_q, satd_d;
    logic          valid_q, valid_d;
    logic          ovr_q, ovr_d;

    logic signed [DW-1:0] row_q  [3];
    logic signed [RW-1:0] rbuf_q [4][4];

    logic                 accept;
    logic signed [RW-1:0] rx [4];
    logic signed [RW-1:0] ry [4];
    logic signed [CW-1:0] cx [4];
    logic signed [CW-1:0] cy [4];
    logic [SW-1:0]        col_sum;

    function automatic logic [CW-1:0] absv(input logic signed [CW-1:0] v);
        return v[CW-1] ? -v : v;
    endfunction

    assign accept = diff_valid && !clear && (state_q == LOAD);

    // Horizontal transform of the completing row (three held + current sample)
    always_comb begin
        rx[0] = {{2{row_q[0][DW-1]}}, row_q[0]};
        rx[1] = {{2{row_q[1][DW-1]}}, row_q[1]};
        rx[2] = {{2{row_q[2][DW-1]}}, row_q[2]};
        rx[3] = {{2{diff_in[DW-1]}}, diff_in};
        ry[0] = rx[0] + rx[1] + rx[2] + rx[3];
        ry[1] = rx[0] + rx[1] - rx[2] - rx[3];
        ry[2] = rx[0] - rx[1] - rx[2] + rx[3];
        ry[3] = rx[0] - rx[1] + rx[2] - rx[3];
    end

    // Vertical transform of buffer column c and the sum of its magnitudes
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            cx[r] = {{2{rbuf_q[r][c_q][RW-1]}}, rbuf_q[r][c_q]};
        end
        cy[0] = cx[0] + cx[1] + cx[2] + cx[3];
        cy[1] = cx[0] + cx[1] - cx[2] - cx[3];
        cy[2] = cx[0] - cx[1] - cx[2] + cx[3];
        cy[3] = cx[0] - cx[1] + cx[2] - cx[3];
        col_sum = SW'(absv(cy[0])) + SW'(absv(cy[1]))
                + SW'(absv(cy[2])) + SW'(absv(cy[3]));
    end

    // Row shift register and row-result buffer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) row_q[i] <= '0;
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) rbuf_q[r][c] <= '0;
        end else if (accept) begin
            if (idx_q[1:0] != 2'd3) begin
                row_q[0] <= row_q[1];
                row_q[1] <= row_q[2];
                row_q[2] <= diff_in;
            end else begin
                for (int c = 0; c < 4; c++) rbuf_q[idx_q[3:2]][c] <= ry[c];
            end
        end
    end

    // Control and accumulator next-state; clear overrides everything
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        c_d     = c_q;
        acc_d   = acc_q;
        satd_d  = satd_q;
        valid_d = 1'b0;
        ovr_d   = ovr_q;
        if (clear) begin
            state_d = LOAD;
            idx_d   = '0;
            c_d     = '0;
            acc_d   = '0;
            ovr_d   = 1'b0;
        end else begin
            unique case (state_q)
                LOAD: begin
                    if (accept) begin
                        idx_d = idx_q + 4'd1;
                        if (idx_q == 4'd15) begin
                            state_d = COL;
                            c_d     = '0;
                            acc_d   = '0;
                        end
                    end
                end
                COL: begin
                    if (diff_valid) ovr_d = 1'b1;
                    acc_d = acc_q + col_sum;
                    c_d   = c_q + 2'd1;
                    if (c_q == 2'd3) begin
                        satd_d  = acc_q + col_sum;
                        valid_d = 1'b1;
                        state_d = LOAD;
                        idx_d   = '0;
                        acc_d   = '0;
                    end
                end
                default: state_d = LOAD;
            endcase
        end
    end

    // Control and accumulator state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= LOAD;
            idx_q   <= '0;
            c_q     <= '0;
            acc_q   <= '0;
            satd_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            c_q     <= c_d;
            acc_q   <= acc_d;
            satd_q  <= satd_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign busy       = (state_q == COL);
    assign satd_valid = valid_q;
    assign satd_out   = satd_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_satd_hadamard_acc.sv
// tb_satd_hadamard_acc: directed bench for satd_hadamard_acc.
// Expected SATD values are hand-derived from the 4x4 Hadamard definition.
module tb_satd_hadamard_acc;

    typedef logic signed [8:0] blk_t [16];

    logic              clk;
    logic              rst;
    logic              clear;
    logic              diff_valid;
    logic signed [8:0] diff_in;
    logic              busy;
    logic              satd_valid;
    logic [16:0]       satd_out;
    logic              overrun;

    int n_cmp;
    int n_bad;

    satd_hadamard_acc #(.DW(9), .SW(17)) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .diff_valid (diff_valid),
        .diff_in    (diff_in),
        .busy       (busy),
        .satd_valid (satd_valid),
        .satd_out   (satd_out),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one sample per negedge; last sample is accepted at the next posedge
    task automatic send(input blk_t v);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            diff_valid = 1'b1;
            diff_in    = v[i];
        end
    endtask

    // Observe 8 half-cycle-offset samples after the last acceptance edge
    task automatic collect(output int lat, output int bcnt,
                           output int vcnt, output logic [16:0] got);
        lat  = 0;
        bcnt = 0;
        vcnt = 0;
        got  = '0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) diff_valid = 1'b0;
            if (busy) bcnt++;
            if (satd_valid) begin
                vcnt++;
                if (lat == 0) begin
                    lat = k;
                    got = satd_out;
                end
            end
        end
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({busy, satd_valid, satd_out, overrun} !== 20'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got b=%b v=%b o=%0d ov=%b want all 0",
                     busy, satd_valid, satd_out, overrun);
        end
    endtask

    task automatic test_zero_block();
        blk_t v;
        int lat, bc, vc;
        logic [16:0] got;
        for (int i = 0; i < 16; i++) v[i] = 9'sd0;
        send(v);
        collect(lat, bc, vc, got);
        n_cmp++;
        if (lat !== 5) begin
            n_bad++;
            $display("FAIL zero_latency: got edges=%0d want 4", lat - 1);
        end
        n_cmp++;
        if (bc !== 4) begin
            n_bad++;
            $display("FAIL zero_busy_cycles: got %0d want 4", bc);
        end
        n_cmp++;
        if (vc !== 1) begin
            n_bad++;
            $display("FAIL zero_pulse_width: got %0d want 1", vc);
        end
        n_cmp++;
        if (got !== 17'd0) begin
            n_bad++;
            $display("FAIL zero_satd: got %0d want 0", got);
        end
    endtask

    task automatic test_patterns();
        blk_t tbl [7];
        int   exp [7];
        int   lat, bc, vc;
        logic [16:0] got;
        for (int i = 0; i < 16; i++) begin
            tbl[0][i] = 9'sd1;
            tbl[1][i] = -9'sd255;
            tbl[2][i] = 9'sd255;
            tbl[3][i] = (i == 0) ? 9'sd5 : 9'sd0;
            tbl[4][i] = (i == 5) ? -9'sd3 : 9'sd0;
            tbl[5][i] = (((i >> 2) + (i & 3)) % 2 == 1) ? -9'sd255 : 9'sd255;
            tbl[6][i] = 9'(i - 8);
        end
        exp = '{16, 4080, 4080, 80, 48, 4080, 128};
        for (int p = 0; p < 7; p++) begin
            send(tbl[p]);
            collect(lat, bc, vc, got);
            n_cmp++;
            if (lat !== 5 || vc !== 1 || got !== 17'(exp[p])) begin
                n_bad++;
                $display("FAIL pattern_%0d: got satd=%0d lat=%0d pulses=%0d want %0d lat=5 pulses=1",
                         p, got, lat, vc, exp[p]);
            end
        end
    endtask

    task automatic test_back_to_back();
        blk_t a, b;
        int lat;
        logic [16:0] got;
        for (int i = 0; i < 16; i++) begin
            a[i] = 9'sd1;
            b[i] = (i == 0) ? 9'sd5 : 9'sd0;
        end
        send(a);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) diff_valid = 1'b0;
        end
        @(negedge clk);
        n_cmp++;
        if (satd_valid !== 1'b1 || satd_out !== 17'd16) begin
            n_bad++;
            $display("FAIL b2b_first: got v=%b satd=%0d want v=1 satd=16",
                     satd_valid, satd_out);
        end
        diff_valid = 1'b1;
        diff_in    = b[0];
        for (int i = 1; i < 16; i++) begin
            @(negedge clk);
            diff_in = b[i];
        end
        lat = 0;
        got = '0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            diff_valid = (k == 2);
            diff_in    = 9'sd100;
            if (satd_valid && lat == 0) begin
                lat = k;
                got = satd_out;
            end
        end
        n_cmp++;
        if (lat !== 5 || got !== 17'd80) begin
            n_bad++;
            $display("FAIL b2b_second: got satd=%0d lat=%0d want 80 lat=5", got, lat);
        end
        n_cmp++;
        if (overrun !== 1'b1) begin
            n_bad++;
            $display("FAIL overrun_set: got %b want 1", overrun);
        end
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        n_cmp++;
        if (overrun !== 1'b0) begin
            n_bad++;
            $display("FAIL overrun_clear: got %b want 0", overrun);
        end
        n_cmp++;
        if (satd_out !== 17'd80) begin
            n_bad++;
            $display("FAIL clear_holds_out: got %0d want 80", satd_out);
        end
    endtask

    task automatic test_abort_clear();
        blk_t v;
        int lat, bc, vc;
        logic [16:0] got;
        for (int i = 0; i < 16; i++) v[i] = 9'sd1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            diff_valid = 1'b1;
            diff_in    = 9'sd100;
        end
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear      = 1'b0;
        diff_valid = 1'b0;
        n_cmp++;
        if (overrun !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL clear_with_valid: got ov=%b busy=%b want 0 0", overrun, busy);
        end
        send(v);
        collect(lat, bc, vc, got);
        n_cmp++;
        if (lat !== 5 || got !== 17'd16) begin
            n_bad++;
            $display("FAIL abort_clear: got satd=%0d lat=%0d want 16 lat=5", got, lat);
        end
    endtask

    task automatic test_abort_reset();
        blk_t v;
        int lat, bc, vc;
        logic [16:0] got;
        for (int i = 0; i < 16; i++) v[i] = 9'sd1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            diff_valid = 1'b1;
            diff_in    = 9'sd100;
        end
        @(negedge clk);
        diff_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if ({busy, satd_valid, satd_out, overrun} !== 20'd0) begin
            n_bad++;
            $display("FAIL async_reset: got b=%b v=%b o=%0d ov=%b want all 0",
                     busy, satd_valid, satd_out, overrun);
        end
        @(negedge clk);
        rst = 1'b1;
        send(v);
        collect(lat, bc, vc, got);
        n_cmp++;
        if (lat !== 5 || got !== 17'd16) begin
            n_bad++;
            $display("FAIL abort_reset: got satd=%0d lat=%0d want 16 lat=5", got, lat);
        end
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        rst        = 1'b0;
        clear      = 1'b0;
        diff_valid = 1'b0;
        diff_in    = '0;
        #12;
        test_reset();
        @(negedge clk);
        rst = 1'b1;
        test_zero_block();
        test_patterns();
        test_back_to_back();
        test_abort_clear();
        test_abort_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
